// File: rtl/utxd_pkt_sched_if.sv
// ---------------------------------------------------------------------------
// utxd_pkt_sched_if
// Bundles the requester, buffer-read and byte-transmitter signals of the
// packet scheduler.
//   req        : per-requester packet request (held until done/err)
//   len0/len1  : packet length per requester, 0..2^AW bytes
//   rd_addr    : byte index into the granted requester's buffer
//   rd_dat0/1  : buffer read data, valid one cycle after rd_addr
//   grant      : one-hot grant, high for the whole packet
//   done/err   : one-cycle completion / watchdog-abort pulse
//   busy       : scheduler is not idle
//   tx_st      : one-cycle transmitter start pulse
//   tx_dat     : byte to the transmitter, stable from tx_st to tx_ce_stop
//   tx_ce_stop : transmitter end-of-stop-bit strobe
// Modports: master = scheduler side, slave = requesters/buffers/transmitter.
// ---------------------------------------------------------------------------
interface utxd_pkt_sched_if #(
    parameter int AW = 4
);
    logic [1:0]    req;
    logic [AW:0]   len0;
    logic [AW:0]   len1;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_dat0;
    logic [7:0]    rd_dat1;
    logic [1:0]    grant;
    logic [1:0]    done;
    logic [1:0]    err;
    logic          busy;
    logic          tx_st;
    logic [7:0]    tx_dat;
    logic          tx_ce_stop;

    modport master (
        input  req, len0, len1, rd_dat0, rd_dat1, tx_ce_stop,
        output rd_addr, grant, done, err, busy, tx_st, tx_dat
    );

    modport slave (
        output req, len0, len1, rd_dat0, rd_dat1, tx_ce_stop,
        input  rd_addr, grant, done, err, busy, tx_st, tx_dat
    );
endinterface

// File: rtl/utxd_pkt_sched.sv
// ---------------------------------------------------------------------------
// utxd_pkt_sched
// Packet-level round-robin scheduler in front of a single-byte UART
// transmitter. Two requesters each own a buffer holding a packet of up to
// 2^AW bytes; a whole packet is the unit of grant. For the granted packet
// each byte is fetched, launched with one tx_st pulse and its stop-bit
// completion (tx_ce_stop) is awaited before the next byte. A watchdog aborts
// the packet with an err pulse if a frame never completes.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   sched_if : utxd_pkt_sched_if master modport (requests, buffer read,
//              grant/done/err/busy, transmitter st/dat/ce_stop)
// ---------------------------------------------------------------------------
module utxd_pkt_sched #(
    parameter int AW        = 4,
    parameter int TO_CYCLES = 8191
) (
    input  logic              clk,
    input  logic              rst,
    utxd_pkt_sched_if.master  sched_if
);

    localparam int WW = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT,
        FIN
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [7:0]    txdat_q, txdat_d;

    logic          pick;
    logic [AW:0]   sel_len;
    logic          wd_limit;
    logic          abort;

    // Arbitration: a lone requester wins outright; on a tie the requester
    // that was not served last wins. last_q holds the index of the last
    // served requester and resets to 1 so requester 0 wins the first tie.
    always_comb begin
        if (sched_if.req == 2'b11) begin
            pick = ~last_q;
        end else begin
            pick = sched_if.req[1];
        end
        sel_len  = pick ? sched_if.len1 : sched_if.len0;
        wd_limit = (wd_q == WW'(TO_CYCLES - 1));
        // A completion strobe in the same cycle as the limit takes priority.
        abort    = (state_q == WAIT) && !sched_if.tx_ce_stop && wd_limit;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            txdat_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            txdat_q <= txdat_d;
        end
    end

    // Next-state and datapath update. Each byte walks FETCH (address out),
    // LOAD (synchronous read data captured into tx_dat), START (launch) and
    // WAIT (stop-bit completion or watchdog). A zero-length packet skips
    // straight to FIN so it completes without touching the transmitter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        txdat_d = txdat_q;
        case (state_q)
            IDLE: begin
                if (sched_if.req != 2'b00) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    cnt_d   = sel_len;
                    addr_d  = '0;
                    state_d = (sel_len == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                txdat_d = grant_q[1] ? sched_if.rd_dat1 : sched_if.rd_dat0;
                state_d = START;
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (sched_if.tx_ce_stop) begin
                    // Address wraps to 0 after the last byte of a full
                    // 2^AW packet; no fetch follows, so this is harmless.
                    cnt_d   = cnt_q - (AW + 1)'(1);
                    addr_d  = addr_q + AW'(1);
                    state_d = (cnt_q == (AW + 1)'(1)) ? FIN : FETCH;
                end else if (wd_limit) begin
                    last_d  = grant_q[1];
                    grant_d = 2'b00;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            FIN: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. err is taken from the abort condition itself so the pulse
    // lands in the last WAIT cycle while grant still names the requester.
    always_comb begin
        sched_if.busy    = (state_q != IDLE);
        sched_if.tx_st   = (state_q == START);
        sched_if.done    = (state_q == FIN) ? grant_q : 2'b00;
        sched_if.err     = abort ? grant_q : 2'b00;
        sched_if.grant   = grant_q;
        sched_if.rd_addr = addr_q;
        sched_if.tx_dat  = txdat_q;
    end

endmodule

// File: tb/tb_utxd_pkt_sched.sv
// ---------------------------------------------------------------------------
// tb_utxd_pkt_sched
// Self-checking bench for utxd_pkt_sched: models both packet buffers and the
// byte transmitter, keeps a scoreboard of expected bytes/done/err events and
// runs a table of single-packet vectors followed by round-robin, watchdog
// and mid-packet reset sequences.
// ---------------------------------------------------------------------------
module tb_utxd_pkt_sched;

    localparam int AW        = 4;
    localparam int TO_CYCLES = 8191;
    localparam int KBYTE     = 0;
    localparam int KDONE     = 1;
    localparam int KERR      = 2;

    typedef struct {
        int            kind;
        logic [7:0]    dat;
        logic [AW-1:0] addr;
        logic [1:0]    who;
    } exp_t;

    typedef struct {
        logic [1:0]  req;
        logic [AW:0] len0;
        logic [AW:0] len1;
        logic [7:0]  base;
        int          frame;
        logic [1:0]  expGrant;
        int          expTx;
        int          maxLat;
    } vec_t;

    logic clk;
    logic rst;

    utxd_pkt_sched_if #(.AW(AW)) bus ();

    utxd_pkt_sched #(
        .AW        (AW),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read buffer models.
    logic [7:0] buf0 [16];
    logic [7:0] buf1 [16];

    always @(posedge clk) begin
        bus.rd_dat0 <= buf0[bus.rd_addr];
        bus.rd_dat1 <= buf1[bus.rd_addr];
    end

    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;
    int         txStTotal = 0;
    int         lastTxStCyc = 0;
    int         errLat = 0;
    logic [1:0] doneNow;
    logic [1:0] errNow;
    exp_t       sbq [$];

    // Transmitter model state.
    int         frameLen = 20;
    int         frameLeft = 0;
    int         frameIdx = 0;
    int         withholdIdx = -1;
    logic       frameActive = 1'b0;
    logic       frameStable = 1'b1;
    logic [7:0] frameByte = 8'h00;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic void pushEv(input int kind, input logic [7:0] dat, input int addr, input logic [1:0] who);
        exp_t e;
        e.kind = kind;
        e.dat  = dat;
        e.addr = addr[AW-1:0];
        e.who  = who;
        sbq.push_back(e);
    endfunction

    // Byte values: buffer 1 holds base+0x80+i so a wrong buffer select shows.
    function automatic logic [7:0] byteOf(input logic [1:0] who, input logic [7:0] base, input int i);
        return (who == 2'b10) ? base + 8'h80 + 8'(i) : base + 8'(i);
    endfunction

    function automatic void fillBufs(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            buf0[i] = byteOf(2'b01, base, i);
            buf1[i] = byteOf(2'b10, base, i);
        end
    endfunction

    function automatic void pushPacket(input logic [1:0] who, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) pushEv(KBYTE, byteOf(who, base, i), i, who);
        pushEv(KDONE, 8'h00, 0, who);
    endfunction

    task automatic popCheck(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL sbUnexpected: got event kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sbq.pop_front();
            check("sbKind", kind, e.kind);
            check("grantAtEvent", bus.grant, e.who);
            if (kind == KBYTE) begin
                check("txDat", bus.tx_dat, e.dat);
                check("rdAddr", bus.rd_addr, e.addr);
            end else if (kind == KDONE) begin
                check("done", bus.done, e.who);
            end else begin
                check("err", bus.err, e.who);
            end
        end
    endtask

    // One clock step: at the falling edge run the transmitter model and
    // compare any DUT event against the scoreboard.
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.tx_ce_stop = 1'b0;
        doneNow = 2'b00;
        errNow  = 2'b00;
        if (rst) begin
            frameActive = 1'b0;
        end else begin
            if (bus.tx_st) begin
                frameActive = 1'b1;
                frameByte   = bus.tx_dat;
                frameLeft   = frameLen;
                frameStable = 1'b1;
            end else if (frameActive) begin
                if (bus.tx_dat !== frameByte) frameStable = 1'b0;
                frameLeft--;
                if (frameLeft == 0) begin
                    frameActive = 1'b0;
                    check("txDatStable", frameStable, 1);
                    if (frameIdx != withholdIdx) bus.tx_ce_stop = 1'b1;
                    frameIdx++;
                end
            end
            if (bus.tx_st) begin
                txStTotal++;
                lastTxStCyc = cyc;
                popCheck(KBYTE);
            end
            if (bus.done != 2'b00) begin
                doneNow = bus.done;
                popCheck(KDONE);
            end
            if (bus.err != 2'b00) begin
                errNow = bus.err;
                errLat = cyc - lastTxStCyc;
                popCheck(KERR);
            end
        end
    endtask

    // Run until nEnds done/err pulses are seen; each requester drops its
    // req on its own pulse unless hold is set.
    task automatic waitEnd(input int budget, input int nEnds, input bit hold,
                           output int lat, output logic [1:0] firstGrant, output int txCount);
        int ends     = 0;
        int tx0      = txStTotal;
        bit finished = 1'b0;
        lat        = 0;
        firstGrant = 2'b00;
        for (int i = 0; i < budget && !finished; i++) begin
            tick();
            lat++;
            if (firstGrant == 2'b00) firstGrant = bus.grant;
            if ((doneNow | errNow) != 2'b00) begin
                ends++;
                if (ends >= nEnds) begin
                    bus.req  = 2'b00;
                    finished = 1'b1;
                end else if (!hold) begin
                    bus.req = bus.req & ~(doneNow | errNow);
                end
            end
        end
        if (!finished) begin
            checks++;
            fails++;
            $display("[TB] FAIL timeout: got %0d end pulses, expected %0d within %0d cycles", ends, nEnds, budget);
            bus.req = 2'b00;
        end
        txCount = txStTotal - tx0;
    endtask

    task automatic checkResetValues();
        check("rstGrant", bus.grant, 2'b00);
        check("rstDone", bus.done, 2'b00);
        check("rstErr", bus.err, 2'b00);
        check("rstBusy", bus.busy, 1'b0);
        check("rstTxSt", bus.tx_st, 1'b0);
        check("rstTxDat", bus.tx_dat, 8'hFF);
        check("rstRdAddr", bus.rd_addr, 0);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        bus.req = 2'b00;
        tick();
        tick();
        checkResetValues();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        frameLen = v.frame;
        fillBufs(v.base);
        bus.len0 = v.len0;
        bus.len1 = v.len1;
        pushPacket(v.expGrant, (v.expGrant == 2'b10) ? int'(v.len1) : int'(v.len0), v.base);
        bus.req = v.req;
    endtask

    task automatic checkOutput(input vec_t v);
        int         lat;
        int         txc;
        logic [1:0] g;
        waitEnd(v.expTx * (v.frame + 10) + 50, 1, 1'b0, lat, g, txc);
        check("vecGrant", g, v.expGrant);
        check("vecTxCount", txc, v.expTx);
        if (v.maxLat > 0) check("vecDoneLatency", lat <= v.maxLat, 1);
        check("vecSbDrained", sbq.size(), 0);
        tick();
        check("vecGrantCleared", bus.grant, 2'b00);
        check("vecBusyCleared", bus.busy, 1'b0);
    endtask

    initial begin
        vec_t       vecs [4];
        int         lat;
        int         txc;
        int         tx0;
        logic [1:0] g;

        vecs[0] = '{2'b01, 5'd3,  5'd0, 8'h41, 4340, 2'b01, 3,  0};
        vecs[1] = '{2'b10, 5'd0,  5'd0, 8'h00, 20,   2'b10, 0,  3};
        vecs[2] = '{2'b01, 5'd16, 5'd0, 8'h00, 20,   2'b01, 16, 0};
        vecs[3] = '{2'b10, 5'd0,  5'd2, 8'h20, 10,   2'b10, 2,  0};

        rst            = 1'b1;
        bus.req        = 2'b00;
        bus.len0       = '0;
        bus.len1       = '0;
        bus.tx_ce_stop = 1'b0;
        fillBufs(8'h00);
        doReset();

        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecs[k]);
            checkOutput(vecs[k]);
        end

        // Round robin with both requests held: 01, 10, 01.
        doReset();
        frameLen = 10;
        fillBufs(8'h50);
        bus.len0 = 5'd1;
        bus.len1 = 5'd1;
        pushPacket(2'b01, 1, 8'h50);
        pushPacket(2'b10, 1, 8'h50);
        pushPacket(2'b01, 1, 8'h50);
        bus.req = 2'b11;
        waitEnd(200, 3, 1'b1, lat, g, txc);
        check("rrFirstGrant", g, 2'b01);
        check("rrTxCount", txc, 3);
        check("rrSbDrained", sbq.size(), 0);

        // Watchdog abort on the 2nd byte; requester 1 is served next.
        doReset();
        frameLen    = 10;
        fillBufs(8'h60);
        bus.len0    = 5'd4;
        bus.len1    = 5'd1;
        withholdIdx = frameIdx + 1;
        pushEv(KBYTE, byteOf(2'b01, 8'h60, 0), 0, 2'b01);
        pushEv(KBYTE, byteOf(2'b01, 8'h60, 1), 1, 2'b01);
        pushEv(KERR, 8'h00, 0, 2'b01);
        pushPacket(2'b10, 1, 8'h60);
        bus.req = 2'b11;
        waitEnd(TO_CYCLES + 200, 2, 1'b0, lat, g, txc);
        withholdIdx = -1;
        check("wdErrLatency", errLat, TO_CYCLES);
        check("wdTxCount", txc, 3);
        check("wdSbDrained", sbq.size(), 0);

        // Reset during WAIT of a 5-byte packet, then restart from byte 0.
        frameLen = 30;
        fillBufs(8'h70);
        bus.len0 = 5'd5;
        pushEv(KBYTE, byteOf(2'b01, 8'h70, 0), 0, 2'b01);
        pushEv(KBYTE, byteOf(2'b01, 8'h70, 1), 1, 2'b01);
        bus.req = 2'b01;
        tx0 = txStTotal;
        for (int i = 0; i < 200 && (txStTotal - tx0) < 2; i++) tick();
        check("rstPktTxBefore", txStTotal - tx0, 2);
        for (int i = 0; i < 5; i++) tick();
        check("rstPktInWait", bus.busy, 1'b1);
        rst     = 1'b1;
        bus.req = 2'b00;
        tick();
        checkResetValues();
        rst = 1'b0;
        check("rstPktSbDrained", sbq.size(), 0);
        tick();
        pushPacket(2'b01, 5, 8'h70);
        bus.req = 2'b01;
        waitEnd(5 * 40 + 50, 1, 1'b0, lat, g, txc);
        check("restartTxCount", txc, 5);
        check("restartSbDrained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
